bf_data_arbiter: RTL
====================

// Module: bf_data_arbiter
// PURPOSE
//  Shares one single-port, 1-cycle-read-latency data RAM between the BF core and a host/debug port.
//  Sits between the core's data_* bus and the RAM, and drives the core's `en`.
//  The core stalls via cpu_en=0 while the host owns the RAM.
//  The core's read data is held stable across host traffic.
// PARAMETERS
//  ADDR_W  8  data RAM address width (matches core DATA_ADDR_WIDTH)
//  DATA_W  8  data word width (matches core DATA_VALUE_WIDTH)
// PORTS
//  clk          in   1       clock, all logic posedge
//  reset        in   1       synchronous, active-high
//  cpu_addr     in   ADDR_W  core data_addr
//  cpu_ren      in   1       core data_ren
//  cpu_wen      in   1       core data_wen
//  cpu_wval     in   DATA_W  core data_wval
//  cpu_rval     out  DATA_W  to core data_rval
//  cpu_en       out  1       to core en; combinational
//  host_req     in   1       host access request; hold with fields stable until host_gnt
//  host_we      in   1       1=write, 0=read
//  host_addr    in   ADDR_W  host address
//  host_wval    in   DATA_W  host write data
//  host_gnt     out  1       1-cycle pulse: host access issued to RAM this cycle
//  host_rvalid  out  1       1-cycle pulse, cycle after a read grant
//  host_rval    out  DATA_W  host read data, valid with host_rvalid
//  ram_addr     out  ADDR_W  RAM address
//  ram_ren      out  1       RAM read enable
//  ram_wen      out  1       RAM write enable
//  ram_wval     out  DATA_W  RAM write data
//  ram_rval     in   DATA_W  RAM read data, valid 1 cycle after ram_ren
//  host_lock    in   1       only with BF_ARB_LOCK_EN (see CONFIGURATION)
// BEHAVIOUR
//  cpu_act  = cpu_ren|cpu_wen
//  Arbitration each cycle:
//  - only cpu_act: CPU wins
//  - only host_req: host wins
//  - both: winner = !last_win (round-robin), where last_win is a register (0=CPU, 1=host)
//  - neither: idle, ram_ren=ram_wen=0
//  Winner drives ram_* combinationally; last_win <= winner on any grant.
//  cpu_en = !(cpu_act & host wins). Idle core cycles are never stalled.
//  A stalled core holds its request next cycle and wins (round-robin) -> max 1 stall cycle per access.
//  cpu_rd_q <= CPU read granted; host_rd_q <= host read granted.
//  cpu_rval = cpu_rd_q ? ram_rval : cpu_hold. cpu_hold <= ram_rval when cpu_rd_q.
//  -> core WB sees its data even when the host accesses RAM in between.
//  host_rvalid = host_rd_q; host_rval = ram_rval that cycle (unregistered).
//  Same-cycle conflict on one address cannot occur (1 port); order is grant order.
//  Reset values: last_win=1 (CPU wins first tie), cpu_rd_q=host_rd_q=0, cpu_hold=0,
//  host_gnt=host_rvalid=0; ram_* go to 0 when idle.
//  Reset mid-access: pending rvalid pulses dropped; no RAM write is issued in the reset cycle.
//  Address/data passthrough: no arithmetic, no wrap; widths exact.
// CONFIGURATION
//  `BF_ARB_LOCK_EN` defined:
//  - host_lock is present. When host_lock=1 and the core has no access in its WB->IF window:
//    cpu_en=0 every cycle and the host wins every cycle (back-to-back grants, debug freeze).
//  - Lock takes effect only when cpu_act=0 and !cpu_rd_q, so it never splits a core read.
//  - Deasserting host_lock restores round-robin next cycle.
//  Undefined: no host_lock port; pure round-robin.
// STRUCTURE
//  Shared include bf_pkg.vh: BF opcode constants (">" "<" "+" "-" "." "," "[" "]"), default widths.
//  No sub-module; the 2-way round-robin pick stays inline (~10 lines).
// TESTING
//  1. CPU-only: core runs "+++." with host_req=0 -> cpu_en=1 throughout, stdout=0x03.
//  2. Host write A=5,D=0xAA then read A=5 -> gnt pulses; rvalid next cycle with 0xAA.
//  3. Tie after reset: cpu_ren@A=0 & host_req same cycle -> CPU granted, cpu_en=1.
//     Next tie -> host granted, cpu_en=0 for exactly 1 cycle.
//  4. Core read of 0x11 followed by a host write of 0x22 to the same address in the core's WB cycle
//     -> core sees 0x11 (cpu_hold).
//  5. Host hammers req every cycle while core runs "++++++++[-]" -> program completes;
//     no core access stalled >1 cycle; final cell 0.
//  6. BF_ARB_LOCK_EN: host_lock=1 mid-program -> cpu_en=0 from the first non-core-access cycle.
//     8 consecutive host grants; lock released -> core resumes, results unchanged.

Source files
------------

// File: rtl/bf_data_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bf_data_arbiter_pkg
//  Description : Shared definitions for the BF data-RAM arbiter: default
//                data-path widths, BF opcode characters and the arbitration
//                winner encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bf_data_arbiter_pkg;

  // Default widths, matching the core's DATA_ADDR_WIDTH / DATA_VALUE_WIDTH.
  localparam int c_ADDR_W = 8;
  localparam int c_DATA_W = 8;

  // BF opcode characters as they appear in program memory.
  localparam logic [7:0] c_OP_RIGHT = 8'h3E;  // '>'
  localparam logic [7:0] c_OP_LEFT  = 8'h3C;  // '<'
  localparam logic [7:0] c_OP_INC   = 8'h2B;  // '+'
  localparam logic [7:0] c_OP_DEC   = 8'h2D;  // '-'
  localparam logic [7:0] c_OP_OUT   = 8'h2E;  // '.'
  localparam logic [7:0] c_OP_IN    = 8'h2C;  // ','
  localparam logic [7:0] c_OP_LOOP  = 8'h5B;  // '['
  localparam logic [7:0] c_OP_END   = 8'h5D;  // ']'

  // Which requester owned the RAM on the most recent grant.
  typedef enum logic {
    WIN_CPU  = 1'b0,
    WIN_HOST = 1'b1
  } win_t;

endpackage : bf_data_arbiter_pkg
`default_nettype wire

// File: rtl/bf_data_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bf_data_arbiter
//  Description : Shares one single-port, 1-cycle-latency data RAM between the
//                BF core and a host/debug port with 2-way round-robin
//                arbitration. The core is stalled (cpu_en=0) only when it
//                requests and loses; its read data is held across host
//                traffic.
//  Ports       : clk, reset (sync, active-high)
//                cpu_*  : core data bus (addr/ren/wen/wval in, rval/en out)
//                host_* : host request/grant, read data with host_rvalid
//                ram_*  : single-port RAM interface
//                host_lock : present only when BF_ARB_LOCK_EN is defined
//  Config      : `define BF_ARB_LOCK_EN adds host_lock (debug freeze).
//  Revision    : 1.0 - initial release
// ============================================================================
module bf_data_arbiter
  import bf_data_arbiter_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_ren,
  input  logic              cpu_wen,
  input  logic [DATA_W-1:0] cpu_wval,
  output logic [DATA_W-1:0] cpu_rval,
  output logic              cpu_en,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wval,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rval,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [DATA_W-1:0] ram_wval,
  input  logic [DATA_W-1:0] ram_rval
`ifdef BF_ARB_LOCK_EN
  ,
  input  logic              host_lock
`endif
);

  win_t              r_last_win;
  logic              r_cpu_rd_q;
  logic              r_host_rd_q;
  logic [DATA_W-1:0] r_cpu_hold;

  logic w_cpu_act;
  logic w_lock;
  logic w_host_pick;
  logic w_host_gnt;
  logic w_cpu_gnt;

  assign w_cpu_act = cpu_ren | cpu_wen;

`ifdef BF_ARB_LOCK_EN
  // Lock only engages outside any core access, including the cycle in which
  // a core read returns, so a core read is never split by the freeze.
  assign w_lock = host_lock & ~w_cpu_act & ~r_cpu_rd_q;
`else
  assign w_lock = 1'b0;
`endif

  // Host wins when locked, when uncontested, or on a tie after a CPU win.
  assign w_host_pick = host_req & (w_lock | ~w_cpu_act | (r_last_win == WIN_CPU));

  // Nothing is issued to the RAM while reset is asserted.
  assign w_host_gnt = ~reset & w_host_pick;
  assign w_cpu_gnt  = ~reset & w_cpu_act & ~w_host_pick;

  assign cpu_en   = ~(w_cpu_act & w_host_pick) & ~w_lock;
  assign host_gnt = w_host_gnt;

  always_comb begin
    ram_addr = '0;
    ram_ren  = 1'b0;
    ram_wen  = 1'b0;
    ram_wval = '0;
    if (w_host_gnt) begin
      ram_addr = host_addr;
      ram_ren  = ~host_we;
      ram_wen  = host_we;
      ram_wval = host_wval;
    end else if (w_cpu_gnt) begin
      ram_addr = cpu_addr;
      ram_ren  = cpu_ren;
      ram_wen  = cpu_wen;
      ram_wval = cpu_wval;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_win  <= WIN_HOST;
      r_cpu_rd_q  <= 1'b0;
      r_host_rd_q <= 1'b0;
      r_cpu_hold  <= '0;
    end else begin
      if (w_host_gnt) begin
        r_last_win <= WIN_HOST;
      end else if (w_cpu_gnt) begin
        r_last_win <= WIN_CPU;
      end
      r_cpu_rd_q  <= w_cpu_gnt & cpu_ren;
      r_host_rd_q <= w_host_gnt & ~host_we;
      // Capture the core's read data so later host reads cannot disturb it.
      if (r_cpu_rd_q) begin
        r_cpu_hold <= ram_rval;
      end
    end
  end

  assign cpu_rval    = r_cpu_rd_q ? ram_rval : r_cpu_hold;
  assign host_rvalid = r_host_rd_q;
  assign host_rval   = ram_rval;

endmodule : bf_data_arbiter
`default_nettype wire
